clock_div_bank: RTL and testbench

Multi-channel, runtime-programmable clock-enable generator; each channel emits a one-cycle `clock_en` strobe every `div+1` cycles of `clock_in` with a programmable phase offset. Divisor/phase updates go through a valid/ready config port and are applied glitch-free at the channel's next rollover. A global `sync` realigns all running channels. The bank sits between the control register block and the interrupter/drive timing logic. It supplies several related timebases from one clock.

---
 rtl/clock_div_bank.sv | 102 ++++++++++
 tb/tb_clock_div_bank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_bank.sv
// Bank of runtime-programmable clock-enable dividers. Each channel strobes clock_en
// every div+1 cycles of clock_in. Config changes are staged in a shadow and applied at rollover.
module clock_div_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] run,
  input  logic                sync,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [WIDTH-1:0]    cfg_phase,
  output logic [CHANNELS-1:0] clock_en,
  output logic [CHANNELS-1:0] pending
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  localparam logic [WIDTH-1:0]  DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [CHAN_W:0]   CH_LIM  = (CHAN_W+1)'(CHANNELS);

  logic chan_ok;
  logic cfg_fire;

  // Writes to a non-existent channel are always accepted and silently dropped.
  assign chan_ok   = ({1'b0, cfg_chan} < CH_LIM);
  assign cfg_ready = ~chan_ok | ~pending[cfg_chan];
  assign cfg_fire  = cfg_valid & cfg_ready & chan_ok;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    chan_state_t      state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] phase_a;
    logic [WIDTH-1:0] div_s;
    logic [WIDTH-1:0] phase_s;
    logic             pend_q;

    logic             run_q;
    logic             rollover;
    logic             apply;
    logic             wr;
    logic [WIDTH-1:0] div_n;
    logic [WIDTH-1:0] phase_n;
    logic [WIDTH-1:0] preload;

    assign run_q    = (state == RUN);
    assign rollover = (cnt >= div_a);
    // A shadow only lands at a period boundary, so a running period never changes length.
    assign apply    = pend_q & (~run_q | sync | rollover);
    assign wr       = cfg_fire & (cfg_chan == CHAN_W'(i));
    assign div_n    = apply ? div_s   : div_a;
    assign phase_n  = apply ? phase_s : phase_a;
    assign preload  = (phase_n > div_n) ? div_n : phase_n;

    assign clock_en[i] = run_q & rollover;
    assign pending[i]  = pend_q;

    // NOTE: sequential state uses non-blocking assignments so every channel samples
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        cnt     <= '0;
        div_a   <= DIV_RST;
        phase_a <= '0;
        div_s   <= DIV_RST;
        phase_s <= '0;
        pend_q  <= 1'b0;
      end else begin
        state <= run[i] ? RUN : IDLE;

        if (!run_q || sync) begin
          cnt <= preload;
        end else if (rollover) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end

        if (apply) begin
          div_a   <= div_s;
          phase_a <= phase_s;
          pend_q  <= 1'b0;
        end else if (wr) begin
          div_s   <= cfg_div;
          phase_s <= cfg_phase;
          pend_q  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_div_bank.sv
// Self-checking bench for clock_div_bank: directed scenarios plus random traffic, compared
// every cycle against a countdown-to-strobe reference model.
module tb_clock_div_bank;

  localparam int NCH  = 5;
  localparam int W    = 16;
  localparam int DDIV = 2;
  localparam int CW   = 3;

  logic           clock_in = 1'b0;
  logic           reset    = 1'b1;
  logic [NCH-1:0] run;
  logic           sync;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_chan;
  logic [W-1:0]   cfg_div;
  logic [W-1:0]   cfg_phase;
  logic [NCH-1:0] clock_en;
  logic [NCH-1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  clock_div_bank #(
    .CHANNELS   (NCH),
    .WIDTH      (W),
    .DEFAULT_DIV(DDIV),
    .CHAN_W     (CW)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .run      (run),
    .sync     (sync),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .clock_en (clock_en),
    .pending  (pending)
  );

  always #5 clock_in = ~clock_in;

  // Reference model: per channel, cycles remaining until the next strobe.
  bit m_run  [NCH];
  bit m_pend [NCH];
  int m_div_a[NCH];
  int m_pha_a[NCH];
  int m_div_s[NCH];
  int m_pha_s[NCH];
  int m_rem  [NCH];

  function automatic logic [NCH-1:0] exp_en();
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_run[i] && (m_rem[i] == 0);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_pend();
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic exp_ready();
    if (int'(cfg_chan) >= NCH) return 1'b1;
    return !m_pend[int'(cfg_chan)];
  endfunction

  always @(posedge clock_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_run[i]   = 0;
        m_pend[i]  = 0;
        m_div_a[i] = DDIV;
        m_div_s[i] = DDIV;
        m_pha_a[i] = 0;
        m_pha_s[i] = 0;
        m_rem[i]   = 0;
      end
    end else begin
      bit fire;
      bit en;
      bit app;
      int nd;
      int np;
      fire = cfg_valid && exp_ready() && (int'(cfg_chan) < NCH);
      for (int i = 0; i < NCH; i++) begin
        en  = m_run[i] && (m_rem[i] == 0);
        app = m_pend[i] && (!m_run[i] || sync || en);
        nd  = app ? m_div_s[i] : m_div_a[i];
        np  = app ? m_pha_s[i] : m_pha_a[i];
        if (!m_run[i] || sync) m_rem[i] = nd - ((np < nd) ? np : nd);
        else if (en)           m_rem[i] = nd;
        else                   m_rem[i] = m_rem[i] - 1;
        if (app) begin
          m_div_a[i] = m_div_s[i];
          m_pha_a[i] = m_pha_s[i];
          m_pend[i]  = 0;
        end else if (fire && int'(cfg_chan) == i) begin
          m_div_s[i] = int'(cfg_div);
          m_pha_s[i] = int'(cfg_phase);
          m_pend[i]  = 1;
        end
        m_run[i] = run[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock_in);
    check("clock_en", 32'(clock_en), 32'(exp_en()));
    check("pending", 32'(pending), 32'(exp_pend()));
    check("cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic cfg_write(input int ch, input int d, input int p);
    cfg_valid = 1'b1;
    cfg_chan  = CW'(ch);
    cfg_div   = W'(d);
    cfg_phase = W'(p);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  initial begin
    run       = '0;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    #12;
    check("rst_clock_en", 32'(clock_en), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'h1);
    @(negedge clock_in);
    reset = 1'b0;

    // Default divisor on channel 0.
    run[0] = 1'b1;
    ticks(15);

    // Idle channel config, then start.
    cfg_write(1, 4, 2);
    ticks(2);
    run[1] = 1'b1;
    ticks(15);

    // Running reconfig: 9 applied at rollover, then 1 with a blocked second write.
    cfg_write(0, 9, 0);
    ticks(12);
    cfg_write(0, 1, 0);
    cfg_write(0, 5, 5);
    ticks(20);

    // Four channels at div 7 with staggered phases, aligned by sync.
    for (int c = 0; c < 4; c++) begin
      cfg_write(c, 7, 2 * c);
      ticks(3);
    end
    ticks(12);
    run[3:0] = 4'hf;
    ticks(3);
    pulse_sync();
    ticks(20);

    // div 0 strobes every cycle; oversized phase is clamped.
    cfg_write(2, 0, 0);
    cfg_write(3, 5, 20);
    ticks(10);
    pulse_sync();
    ticks(10);
    run[3] = 1'b0;
    ticks(2);
    run[3] = 1'b1;
    ticks(8);

    // Out-of-range channel write is accepted and dropped.
    cfg_chan = 3'd6;
    #1;
    check("oor_ready", 32'(cfg_ready), 32'h1);
    cfg_write(6, 1, 1);
    cfg_write(7, 3, 0);
    ticks(5);

    // Asynchronous reset while a shadow is pending on a running channel.
    run = '0;
    run[0] = 1'b1;
    cfg_write(0, 30, 0);
    ticks(40);
    pulse_sync();
    ticks(2);
    cfg_write(0, 3, 0);
    ticks(3);
    check("pend_before_rst", 32'(pending[0]), 32'h1);
    @(posedge clock_in);
    #2;
    reset = 1'b1;
    #1;
    check("async_clock_en", 32'(clock_en), 32'h0);
    check("async_pending", 32'(pending), 32'h0);
    check("async_cfg_ready", 32'(cfg_ready), 32'h1);
    @(negedge clock_in);
    reset = 1'b0;
    ticks(15);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 19) == 0) run[i] = ~run[i];
      sync      = ($urandom_range(0, 29) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_chan  = CW'($urandom_range(0, 7));
      cfg_div   = W'($urandom_range(0, 12));
      cfg_phase = W'($urandom_range(0, 15));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
